// File: rtl/axil2lb_bridge.sv
// axil2lb_bridge: AXI4-Lite slave to local-bus master bridge.
// Independent write and read engines, one transaction in flight each.
// Addresses >= ADDR_LIMIT return DECERR without touching the local bus.
// Define AXIL2LB_TIMEOUT_EN to bound ACCESS at 2**TIMEOUT_W cycles (SLVERR).
module axil2lb_bridge #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STRB_W     = DATA_W / 8,
  parameter int ADDR_LIMIT = 4096,
  parameter int TIMEOUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] axil_awaddr,
  input  logic [2:0]        axil_awprot,
  input  logic              axil_awvalid,
  output logic              axil_awready,
  input  logic [DATA_W-1:0] axil_wdata,
  input  logic [STRB_W-1:0] axil_wstrb,
  input  logic              axil_wvalid,
  output logic              axil_wready,
  output logic [1:0]        axil_bresp,
  output logic              axil_bvalid,
  input  logic              axil_bready,
  input  logic [ADDR_W-1:0] axil_araddr,
  input  logic [2:0]        axil_arprot,
  input  logic              axil_arvalid,
  output logic              axil_arready,
  output logic [DATA_W-1:0] axil_rdata,
  output logic [1:0]        axil_rresp,
  output logic              axil_rvalid,
  input  logic              axil_rready,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wen,
  input  logic              wready,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid
);

  typedef enum logic [1:0] {W_IDLE, W_ACCESS, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} r_state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [31:0] LIMIT       = 32'(ADDR_LIMIT);

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} >= LIMIT;
  endfunction

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] waddr_q, raddr_q, w_addr_cur;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_hs, w_hs, ar_hs, w_tmo, r_tmo;
  logic              unused_prot;

  assign unused_prot = ^{axil_awprot, axil_arprot};

  assign aw_hs = axil_awvalid & awready_q;
  assign w_hs  = axil_wvalid & wready_q;
  assign ar_hs = axil_arvalid & arready_q;
  // Decode must see the address in the cycle AW is accepted as well as later.
  assign w_addr_cur = aw_hs ? axil_awaddr : waddr_q;

`ifdef AXIL2LB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] w_cnt_q, r_cnt_q;

  assign w_tmo = (w_state_q == W_ACCESS) && !wready && (w_cnt_q == '1);
  assign r_tmo = (r_state_q == R_ACCESS) && !rvalid && (r_cnt_q == '1);

  // Wait-state counters: zero outside ACCESS, count cycles without handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cnt_q <= '0;
      r_cnt_q <= '0;
    end else begin
      if (w_state_q != W_ACCESS) w_cnt_q <= '0;
      else if (!wready)          w_cnt_q <= w_cnt_q + 1'b1;
      if (r_state_q != R_ACCESS) r_cnt_q <= '0;
      else if (!rvalid)          r_cnt_q <= r_cnt_q + 1'b1;
    end
  end
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign w_tmo = 1'b0;
  assign r_tmo = 1'b0;
`endif

  // Write engine state, capture flags and registered AXI handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write next-state: collect AW and W in any order, decode, access, respond.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        aw_got_d = aw_got_q | aw_hs;
        w_got_d  = w_got_q | w_hs;
        if (aw_got_d && w_got_d) begin
          if (out_of_range(w_addr_cur)) begin
            w_state_d = W_RESP;
            bresp_d   = RESP_DECERR;
          end else begin
            w_state_d = W_ACCESS;
          end
        end
      end
      W_ACCESS: begin
        if (wready) begin
          w_state_d = W_RESP;
          bresp_d   = RESP_OKAY;
        end else if (w_tmo) begin
          w_state_d = W_RESP;
          bresp_d   = RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (axil_bready) begin
          w_state_d = W_IDLE;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Readies only re-open after a full cycle in IDLE.
    awready_d = (w_state_q == W_IDLE) && (w_state_d == W_IDLE) && !aw_got_d;
    wready_d  = (w_state_q == W_IDLE) && (w_state_d == W_IDLE) && !w_got_d;
  end

  // Read engine state and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Read next-state: capture AR, decode, wait for local data, respond.
  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (out_of_range(axil_araddr)) begin
            r_state_d = R_RESP;
            rresp_d   = RESP_DECERR;
            rdata_d   = '0;
          end else begin
            r_state_d = R_ACCESS;
          end
        end
      end
      R_ACCESS: begin
        if (rvalid) begin
          r_state_d = R_RESP;
          rresp_d   = RESP_OKAY;
          rdata_d   = rdata;
        end else if (r_tmo) begin
          r_state_d = R_RESP;
          rresp_d   = RESP_SLVERR;
          rdata_d   = '0;
        end
      end
      R_RESP: if (axil_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_q == R_IDLE) && (r_state_d == R_IDLE);
  end

  // Address/data capture; held stable for the whole local access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      raddr_q <= '0;
    end else begin
      if (aw_hs) waddr_q <= axil_awaddr;
      if (w_hs) begin
        wdata_q <= axil_wdata;
        wstrb_q <= axil_wstrb;
      end
      if (ar_hs) raddr_q <= axil_araddr;
    end
  end

  assign axil_awready = awready_q;
  assign axil_wready  = wready_q;
  assign axil_bvalid  = (w_state_q == W_RESP);
  assign axil_bresp   = bresp_q;
  assign axil_arready = arready_q;
  assign axil_rvalid  = (r_state_q == R_RESP);
  assign axil_rresp   = rresp_q;
  assign axil_rdata   = rdata_q;
  assign wen          = (w_state_q == W_ACCESS);
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign ren          = (r_state_q == R_ACCESS);
  assign raddr        = raddr_q;

endmodule
